// File: rtl/chaotic_x_update_mc_if.sv
// Bus bundle for the chaotic x-update pipeline: sample input, sine-core
// request/response, result output and sticky status.
interface chaotic_x_update_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_W       = 2
);
    logic                  in_valid;
    logic [CH_W-1:0]       in_ch;
    logic [DATA_WIDTH-1:0] yn;
    logic [DATA_WIDTH-1:0] zn;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] c;
    logic [DATA_WIDTH-1:0] e;
    logic [DATA_WIDTH-1:0] k0;
    logic [DATA_WIDTH-1:0] k1;
    logic [DATA_WIDTH-1:0] k2;

    logic                  sin_req_valid;
    logic [DATA_WIDTH-1:0] sin_theta;
    logic                  sin_res_valid;
    logic [DATA_WIDTH-1:0] sin_res;

    logic                  xn1_valid;
    logic [CH_W-1:0]       xn1_ch;
    logic [DATA_WIDTH-1:0] xn1;
    logic                  busy;

    logic                  clr_status;
    logic                  sat_flag;
    logic                  sin_err;
    logic                  ch_err;

    // Pipeline view.
    modport slave (
        input  in_valid, in_ch, yn, zn, a, c, e, k0, k1, k2,
        input  sin_res_valid, sin_res, clr_status,
        output sin_req_valid, sin_theta,
        output xn1_valid, xn1_ch, xn1, busy,
        output sat_flag, sin_err, ch_err
    );

    // Upstream / sine-core / controller view.
    modport master (
        output in_valid, in_ch, yn, zn, a, c, e, k0, k1, k2,
        output sin_res_valid, sin_res, clr_status,
        input  sin_req_valid, sin_theta,
        input  xn1_valid, xn1_ch, xn1, busy,
        input  sat_flag, sin_err, ch_err
    );
endinterface

// File: rtl/chaotic_x_update_mc.sv
// Multi-channel saturating fixed-point x-update:
//   x[n+1] = a*y + c*sin(e*(k0 + k1*z + k2*z^2)*y)
// Six registered stages around an external fixed-latency sine core; the
// terms not needed by the sine core ride a delay line matched to its latency.
module chaotic_x_update_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC       = 16,
    parameter int NUM_CH     = 4,
    parameter int SIN_LAT    = 8,
    localparam int CH_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input logic                  clk,
    input logic                  rst,
    chaotic_x_update_mc_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    typedef struct packed {
        logic          sat;
        logic [DW-1:0] val;
    } sat_t;

    // Full-width product, floor shift by FRAC, saturate to DW bits.
    function automatic sat_t mul_sat(input logic signed [DW-1:0] x,
                                     input logic signed [DW-1:0] y);
        logic signed [2*DW-1:0] p;
        logic [DW:0]            hi;
        sat_t                   r;
        p     = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
        p     = p >>> FRAC;
        hi    = p[2*DW-1:DW-1];
        r.sat = !((&hi) || !(|hi));
        r.val = r.sat ? (p[2*DW-1] ? MIN_V : MAX_V) : p[DW-1:0];
        return r;
    endfunction

    // One-bit-wider sum, saturate to DW bits.
    function automatic sat_t add_sat(input logic signed [DW-1:0] x,
                                     input logic signed [DW-1:0] y);
        logic signed [DW:0] s;
        sat_t               r;
        s     = {x[DW-1], x} + {y[DW-1], y};
        r.sat = s[DW] ^ s[DW-1];
        r.val = r.sat ? (s[DW] ? MIN_V : MAX_V) : s[DW-1:0];
        return r;
    endfunction

    logic            in_ok, in_bad;
    logic            v1, v2, v3, v4, v5;
    logic [CH_W-1:0] ch1, ch2, ch3, ch4, ch5;
    logic [DW-1:0]   zz1, k1z1, ay1, ey1, k0_1, k2_1, c1;
    logic [DW-1:0]   lin2, k2zz2, ay2, ey2, c2;
    logic [DW-1:0]   poly3, ay3, ey3, c3;
    logic [DW-1:0]   theta4, ay4, c4;
    logic [DW-1:0]   cs5, ay5;
    logic            out_valid;
    logic [CH_W-1:0] out_ch;
    logic [DW-1:0]   out_x;

    logic [SIN_LAT-1:0] dl_v;
    logic [CH_W-1:0]    dl_ch [SIN_LAT];
    logic [DW-1:0]      dl_ay [SIN_LAT];
    logic [DW-1:0]      dl_c  [SIN_LAT];

    sat_t m_zz, m_k1z, m_ay, m_ey, a_lin, m_k2zz, a_poly, m_theta, m_cs, a_x;
    logic sat_evt;
    logic sat_r, sin_err_r, ch_err_r;

    assign in_ok  = bus.in_valid && ({1'b0, bus.in_ch} < NUM_CH_L);
    assign in_bad = bus.in_valid && !({1'b0, bus.in_ch} < NUM_CH_L);

    // Per-stage arithmetic and the combined saturation event of valid samples.
    always_comb begin
        // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
        m_zz    = mul_sat(bus.zn, bus.zn);
        m_k1z   = mul_sat(bus.k1, bus.zn);
        m_ay    = mul_sat(bus.a,  bus.yn);
        m_ey    = mul_sat(bus.e,  bus.yn);
        a_lin   = add_sat(k0_1, k1z1);
        m_k2zz  = mul_sat(k2_1, zz1);
        a_poly  = add_sat(lin2, k2zz2);
        m_theta = mul_sat(poly3, ey3);
        m_cs    = mul_sat(dl_c[SIN_LAT-1], bus.sin_res);
        a_x     = add_sat(ay5, cs5);
        sat_evt = (in_ok && (m_zz.sat || m_k1z.sat || m_ay.sat || m_ey.sat))
               || (v1 && (a_lin.sat || m_k2zz.sat))
               || (v2 && a_poly.sat)
               || (v3 && m_theta.sat)
               || (dl_v[SIN_LAT-1] && m_cs.sat)
               || (v5 && a_x.sat);
    end

    // Front stages R1..R4: polynomial, angle and sine request.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        if (rst) begin
            {v1, v2, v3, v4} <= '0;
            {ch1, ch2, ch3, ch4} <= '0;
            {zz1, k1z1, ay1, ey1, k0_1, k2_1, c1} <= '0;
            {lin2, k2zz2, ay2, ey2, c2} <= '0;
            {poly3, ay3, ey3, c3} <= '0;
            {theta4, ay4, c4} <= '0;
        end else begin
            v1 <= in_ok;  ch1 <= bus.in_ch;
            zz1 <= m_zz.val;  k1z1 <= m_k1z.val;  ay1 <= m_ay.val;  ey1 <= m_ey.val;
            k0_1 <= bus.k0;   k2_1 <= bus.k2;     c1 <= bus.c;

            v2 <= v1;  ch2 <= ch1;
            lin2 <= a_lin.val;  k2zz2 <= m_k2zz.val;  ay2 <= ay1;  ey2 <= ey1;  c2 <= c1;

            v3 <= v2;  ch3 <= ch2;
            poly3 <= a_poly.val;  ay3 <= ay2;  ey3 <= ey2;  c3 <= c2;

            v4 <= v3;  ch4 <= ch3;
            theta4 <= m_theta.val;  ay4 <= ay3;  c4 <= c3;
        end
    end

    // Delay-line valids, aligned with the sine core latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v <= '0;
        end else begin
            dl_v[0] <= v4;
            for (int i = 1; i < SIN_LAT; i++) dl_v[i] <= dl_v[i-1];
        end
    end

    // Delay-line payload travelling alongside its valid bit.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is not reset; the reset valid bits alone decide what is live.
        dl_ch[0] <= ch4;  dl_ay[0] <= ay4;  dl_c[0] <= c4;
        for (int i = 1; i < SIN_LAT; i++) begin
            dl_ch[i] <= dl_ch[i-1];
            dl_ay[i] <= dl_ay[i-1];
            dl_c[i]  <= dl_c[i-1];
        end
    end

    // Back stages R5..R6: scale the sine result and form x[n+1]; output holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v5 <= 1'b0;  ch5 <= '0;  cs5 <= '0;  ay5 <= '0;
            out_valid <= 1'b0;  out_ch <= '0;  out_x <= '0;
        end else begin
            v5  <= dl_v[SIN_LAT-1];
            ch5 <= dl_ch[SIN_LAT-1];
            cs5 <= m_cs.val;
            ay5 <= dl_ay[SIN_LAT-1];
            out_valid <= v5;
            if (v5) begin
                out_ch <= ch5;
                out_x  <= a_x.val;
            end
        end
    end

    // Sticky status: set wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_r <= 1'b0;  sin_err_r <= 1'b0;  ch_err_r <= 1'b0;
        end else begin
            sat_r     <= (sat_r     && !bus.clr_status) || sat_evt;
            sin_err_r <= (sin_err_r && !bus.clr_status) || (bus.sin_res_valid != dl_v[SIN_LAT-1]);
            ch_err_r  <= (ch_err_r  && !bus.clr_status) || in_bad;
        end
    end

    assign bus.sin_req_valid = v4;
    assign bus.sin_theta     = theta4;
    assign bus.xn1_valid     = out_valid;
    assign bus.xn1_ch        = out_ch;
    assign bus.xn1           = out_x;
    assign bus.busy          = v1 || v2 || v3 || v4 || (|dl_v) || v5 || out_valid;
    assign bus.sat_flag      = sat_r;
    assign bus.sin_err       = sin_err_r;
    assign bus.ch_err        = ch_err_r;
endmodule

// File: tb/tb_chaotic_x_update_mc.sv
// Directed bench for chaotic_x_update_mc with a sine stub that echoes theta
// after SIN_LAT cycles and can suppress one result-valid pulse.
module tb_chaotic_x_update_mc;
    localparam int DW      = 32;
    localparam int FRAC    = 16;
    localparam int NUM_CH  = 5;
    localparam int SIN_LAT = 8;
    localparam int CH_W    = 3;
    localparam logic [DW-1:0] ONE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drop_res = 1'b0;
    int   evaluated = 0;
    int   failures  = 0;
    logic seen_out;

    chaotic_x_update_mc_if #(.DATA_WIDTH(DW), .CH_W(CH_W)) bus ();

    chaotic_x_update_mc #(
        .DATA_WIDTH(DW), .FRAC(FRAC), .NUM_CH(NUM_CH), .SIN_LAT(SIN_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sine stub: sin(theta) := theta, fixed latency SIN_LAT.
    logic          stub_v [SIN_LAT];
    logic [DW-1:0] stub_d [SIN_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIN_LAT; i++) begin
                stub_v[i] <= 1'b0;
                stub_d[i] <= '0;
            end
        end else begin
            stub_v[0] <= bus.sin_req_valid;
            stub_d[0] <= bus.sin_theta;
            for (int i = 1; i < SIN_LAT; i++) begin
                stub_v[i] <= stub_v[i-1];
                stub_d[i] <= stub_d[i-1];
            end
        end
    end
    assign bus.sin_res_valid = stub_v[SIN_LAT-1] & ~drop_res;
    assign bus.sin_res       = stub_d[SIN_LAT-1];

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input logic [CH_W-1:0] ch, input logic [DW-1:0] a, c, e,
                         k0, k1, k2, y, z);
        bus.in_valid = 1'b1;  bus.in_ch = ch;
        bus.a = a;  bus.c = c;  bus.e = e;
        bus.k0 = k0;  bus.k1 = k1;  bus.k2 = k2;
        bus.yn = y;  bus.zn = z;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_status();
        bus.clr_status = 1'b1;
        tick();
        bus.clr_status = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;  bus.in_ch = '0;  bus.clr_status = 1'b0;
        bus.a = '0;  bus.c = '0;  bus.e = '0;
        bus.k0 = '0;  bus.k1 = '0;  bus.k2 = '0;
        bus.yn = '0;  bus.zn = '0;

        // Reset state.
        run(3);
        check("rst_xn1_valid", bus.xn1_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sin_req", bus.sin_req_valid, 0);
        check("rst_sin_theta", bus.sin_theta, 0);
        check("rst_xn1", bus.xn1, 0);
        check("rst_xn1_ch", bus.xn1_ch, 0);
        check("rst_flags", {bus.sat_flag, bus.sin_err, bus.ch_err}, 0);
        rst = 1'b0;
        run(2);

        // Linear path: theta = 0.5, xn1 = 2.0 * 0.5 = 1.0.
        drive(0, 32'h0, 32'h0002_0000, ONE, ONE, 32'h0, 32'h0, 32'h0000_8000, 32'h0);
        tick();  idle();
        run(3);
        check("lin_sin_req", bus.sin_req_valid, 1);
        check("lin_sin_theta", bus.sin_theta, 32'h0000_8000);
        check("lin_busy", bus.busy, 1);
        run(10);
        check("lin_valid", bus.xn1_valid, 1);
        check("lin_xn1", bus.xn1, 32'h0001_0000);
        check("lin_ch", bus.xn1_ch, 0);
        tick();
        check("lin_valid_drop", bus.xn1_valid, 0);
        check("lin_hold", bus.xn1, 32'h0001_0000);
        check("lin_busy_fall", bus.busy, 0);
        check("lin_no_sat", bus.sat_flag, 0);
        check("lin_no_sin_err", bus.sin_err, 0);

        // Floor: -1.0 * 1 LSB floors to -1 LSB.
        drive(1, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0001, 32'h0);
        tick();  idle();
        run(13);
        check("floor_valid", bus.xn1_valid, 1);
        check("floor_xn1", bus.xn1, 32'hFFFF_FFFF);
        check("floor_ch", bus.xn1_ch, 1);
        check("floor_no_sat", bus.sat_flag, 0);

        // Saturate: 32767.0 * 2.0 clips to max positive.
        drive(2, 32'h7FFF_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0002_0000, 32'h0);
        tick();  idle();
        check("sat_flag_set", bus.sat_flag, 1);
        run(13);
        check("sat_xn1", bus.xn1, 32'h7FFF_FFFF);
        check("sat_valid", bus.xn1_valid, 1);
        clear_status();
        check("sat_flag_clr", bus.sat_flag, 0);
        run(2);

        // Interleave channels 0..3 then an illegal tag 5.
        for (int i = 0; i < 4; i++) begin
            drive(CH_W'(i), ONE * i, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ONE, 32'h0);
            tick();
        end
        drive(5, 32'h0005_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ONE, 32'h0);
        tick();  idle();
        check("ch_err_set", bus.ch_err, 1);
        run(9);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("il_valid_%0d", i), bus.xn1_valid, 1);
            check($sformatf("il_ch_%0d", i), bus.xn1_ch, i);
            check($sformatf("il_xn1_%0d", i), bus.xn1, ONE * i);
            tick();
        end
        check("il_drop_bad", bus.xn1_valid, 0);
        clear_status();
        check("ch_err_clr", bus.ch_err, 0);
        run(2);

        // Coefficient change between consecutive samples.
        drive(2, ONE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ONE, 32'h0);
        tick();
        drive(2, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ONE, 32'h0);
        tick();  idle();
        run(12);
        check("coef_first", bus.xn1, ONE);
        check("coef_first_v", bus.xn1_valid, 1);
        tick();
        check("coef_second", bus.xn1, 32'h0002_0000);
        check("coef_second_v", bus.xn1_valid, 1);
        run(2);

        // Sine fault: suppress the result-valid pulse of one sample.
        drive(0, 32'h0, 32'h0002_0000, ONE, ONE, 32'h0, 32'h0, 32'h0000_8000, 32'h0);
        tick();  idle();
        run(11);
        check("sinf_before", bus.sin_err, 0);
        drop_res = 1'b1;
        tick();
        drop_res = 1'b0;
        check("sinf_set", bus.sin_err, 1);
        tick();
        check("sinf_out_valid", bus.xn1_valid, 1);
        check("sinf_out_xn1", bus.xn1, 32'h0001_0000);
        clear_status();
        check("sinf_clr", bus.sin_err, 0);
        run(2);

        // Reset mid-stream with five samples in flight.
        for (int i = 0; i < 5; i++) begin
            drive(CH_W'(i % 4), ONE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ONE, 32'h0);
            tick();
        end
        idle();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.xn1_valid, 0);
        tick();
        rst = 1'b0;
        seen_out = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.xn1_valid || bus.sin_req_valid) seen_out = 1'b1;
        end
        check("post_rst_no_out", seen_out, 0);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_sin_err", bus.sin_err, 0);

        drive(3, 32'h0003_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ONE, 32'h0);
        tick();  idle();
        run(12);
        check("post_rst_early", bus.xn1_valid, 0);
        tick();
        check("post_rst_valid", bus.xn1_valid, 1);
        check("post_rst_xn1", bus.xn1, 32'h0003_0000);
        check("post_rst_ch", bus.xn1_ch, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end
endmodule
